fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
//  Initiator side of the FPU core: accepts operand/opcode commands on a valid/ready
//  stream, drives the FPU core's operand/opcode inputs, and captures each registered
//  result with its flags after the fixed core latency. Results are buffered and returned
//  in order with the command tag on a second valid/ready stream.
//  Sits between the command source (sequencer/CPU bridge) and FPU_Core. Sustains 1 op/cycle.
// PARAMETERS
//  TAG_W      4   width of command/response tag
//  RSP_DEPTH  4   response FIFO entries; also max outstanding (in flight + buffered)
//  FPU_LAT    1   FPU core cycles from operand input to registered output (>=1)
// PORTS
//  Clk            in   1     clock
//  Rst            in   1     synchronous, active-high reset
//  cmd_valid      in   1     command present
//  cmd_ready      out  1     command accepted when cmd_valid & cmd_ready
//  cmd_op         in   4     0 add, 1 sub, 2 mul, 3 div; others illegal
//  cmd_a, cmd_b   in   32    IEEE-754 single operands
//  cmd_tag        in   TAG_W returned unchanged with the response
//  fpu_a, fpu_b   out  32    to core a_operand/b_operand (registered)
//  fpu_op         out  4     to core Operation (registered)
//  fpu_result     in   32    core FPU_Output
//  fpu_exc, fpu_ovf, fpu_unf  in 1 each  core Exception/Overflow/Underflow
//  rsp_valid      out  1     response present
//  rsp_ready      in   1     response consumed when rsp_valid & rsp_ready
//  rsp_result     out  32    result word
//  rsp_flags      out  4     {illegal, underflow, overflow, exception}
//  rsp_tag        out  TAG_W tag of the originating command
//  err_cnt        out  16    count of responses with any flag set, saturating
// BEHAVIOUR
//  Reset (sync, high): cmd_ready=0 during Rst; rsp_valid=0; fpu_a=fpu_b=0; fpu_op=4'hF;
//   err_cnt=0; in-flight pipe and FIFO cleared. Reset mid-operation discards all in-flight
//   and buffered work; no stale response after Rst deasserts. Core reset tied to ~Rst.
//  Credit: cmd_ready = ~Rst & (fifo_count + inflight < RSP_DEPTH), from registered state
//   only; no combinational path rsp_ready -> cmd_ready. A pop frees a credit next cycle.
//  Issue: fire in cycle t -> fpu_a/fpu_b/fpu_op hold the command in cycle t+1; {valid,tag,
//   illegal} enters a FPU_LAT+1 stage shift pipe. No fire -> fpu_op=4'hF, operands 0.
//  Capture: at stage end (cycle t+1+FPU_LAT) write {fpu_result, flags, tag} into the FIFO;
//   rsp_valid earliest cycle t+2+FPU_LAT (=3 at default). Illegal op: fpu_op=4'hF driven,
//   result forced 0, flags=4'b1000; core flags ignored.
//  Legal op: flags = {0, fpu_unf, fpu_ovf, fpu_exc}, result = fpu_result unmodified.
//  Order: responses strictly in command order. Simultaneous FIFO write and pop allowed,
//   including when full-minus-one or empty (write-through not required; 1-cycle bubble ok).
//  FIFO overflow impossible by credit; assertion: write when full is an error.
//  err_cnt: +1 on each FIFO write with flags!=0; holds at 16'hFFFF.
//  rsp_* stable while rsp_valid & ~rsp_ready.
// STRUCTURE
//  Shared package fpu_pkg: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_IDLE=4'hF;
//   flag bit indices FLG_EXC=0, FLG_OVF=1, FLG_UNF=2, FLG_ILL=3.
//  Sub-module fpu_rsp_fifo: synchronous FIFO, depth RSP_DEPTH, width 32+4+TAG_W, with count.
//  Top: issue registers, latency shift pipe, credit logic, err counter.
// TESTING
//  ADD 0x3F800000+0x40000000 tag 1, fire cycle 0 -> rsp_valid cycle 3, 0x40400000, flags 0, tag 1.
//  MUL 0x40000000*0x40400000, DIV 0x3F800000/0x40000000, SUB 0x3F800000-0x3F800000 back-to-back,
//   rsp_ready=1 -> 0x40C00000, 0x3F000000, 0x00000000 on consecutive cycles, tags in order.
//  rsp_ready=0, 6 commands offered -> exactly 4 fire, cmd_ready stays 0; raise rsp_ready ->
//   remaining 2 issue, all 6 responses in order, no loss or duplication.
//  op=4'd7 -> result 0, flags 4'b1000, fpu_op seen as 4'hF, err_cnt increments by 1.
//  MUL 0x7F000000*0x7F000000 -> rsp_flags[1] mirrors core Overflow, err_cnt +1.
//  Rst 1 cycle with 2 in flight and 2 buffered -> rsp_valid=0 next cycle, err_cnt=0,
//   cmd_ready=1 after Rst drops, no stale responses ever appear.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU opcodes, response flag bit positions and opcode legality helper.
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_IDLE = 4'hF
  } fpu_op_e;

  localparam int FLG_EXC = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 2;
  localparam int FLG_ILL = 3;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd3;
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// In-order response buffer with occupancy count; reads are from the registered head entry.
module fpu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_en, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Upstream credit accounting guarantees space for every write.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU core initiator: registered operand issue, fixed-latency capture pipe, credit-gated
// command acceptance and in-order tagged response return.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4,
  parameter int FPU_LAT   = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [3:0]       fpu_op,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_exc,
  input  logic             fpu_ovf,
  input  logic             fpu_unf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      err_cnt
);

  localparam int ENT_W = 32 + 4 + TAG_W;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W = $clog2(RSP_DEPTH + FPU_LAT + 2);

  logic [31:0]                fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [3:0]                 fpu_op_q, fpu_op_d;
  logic [FPU_LAT:0]           vld_pipe_q, vld_pipe_d, ill_pipe_q, ill_pipe_d;
  logic [FPU_LAT:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;
  logic [15:0]                err_cnt_q, err_cnt_d;
  logic                       fire, legal, cap, pop, fifo_empty;
  logic [CNT_W-1:0]           fifo_cnt;
  logic [SUM_W-1:0]           inflight;
  logic [31:0]                cap_result;
  logic [3:0]                 cap_flags;
  logic [ENT_W-1:0]           rd_data;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= FPU_LAT; i++) inflight = inflight + SUM_W'(vld_pipe_q[i]);
  end

  // Credits come only from registered occupancy, so a pop frees a slot one cycle later.
  assign cmd_ready = ~Rst & ((SUM_W'(fifo_cnt) + inflight) < SUM_W'(RSP_DEPTH));
  assign fire      = cmd_valid & cmd_ready;
  assign legal     = op_legal(cmd_op);

  always_comb begin
    fpu_a_d  = '0;
    fpu_b_d  = '0;
    fpu_op_d = OP_IDLE;
    if (fire) begin
      fpu_a_d  = cmd_a;
      fpu_b_d  = cmd_b;
      fpu_op_d = legal ? cmd_op : OP_IDLE;
    end
    vld_pipe_d = {vld_pipe_q[FPU_LAT-1:0], fire};
    ill_pipe_d = {ill_pipe_q[FPU_LAT-1:0], fire & ~legal};
    tag_pipe_d = {tag_pipe_q[FPU_LAT-1:0], cmd_tag};
  end

  // Last pipe stage lines up with the core's registered output for that command.
  assign cap = vld_pipe_q[FPU_LAT];

  always_comb begin
    cap_result = fpu_result;
    cap_flags  = '0;
    if (ill_pipe_q[FPU_LAT]) begin
      cap_result         = '0;
      cap_flags[FLG_ILL] = 1'b1;
    end else begin
      cap_flags[FLG_EXC] = fpu_exc;
      cap_flags[FLG_OVF] = fpu_ovf;
      cap_flags[FLG_UNF] = fpu_unf;
    end
    err_cnt_d = err_cnt_q;
    if (cap && (cap_flags != '0) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= OP_IDLE;
      vld_pipe_q <= '0;
      ill_pipe_q <= '0;
      tag_pipe_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_op_q   <= fpu_op_d;
      vld_pipe_q <= vld_pipe_d;
      ill_pipe_q <= ill_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  fpu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (ENT_W)
  ) u_rsp_fifo (
    .clk     (Clk),
    .rst     (Rst),
    .wr_en   (cap),
    .wr_data ({cap_result, cap_flags, tag_pipe_q[FPU_LAT]}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;
  assign {rsp_result, rsp_flags, rsp_tag} = rd_data;
  assign fpu_a   = fpu_a_q;
  assign fpu_b   = fpu_b_q;
  assign fpu_op  = fpu_op_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a table-driven single-cycle FPU core model.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int TAG_W = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [31:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      fpu_a, fpu_b;
  logic [3:0]       fpu_op;
  logic [31:0]      fpu_result;
  logic             fpu_exc, fpu_ovf, fpu_unf;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      err_cnt;

  typedef struct packed {
    logic [31:0]      res;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, n_fired = 0, exp_err = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  fpu_issue_ctrl #(.TAG_W(TAG_W), .RSP_DEPTH(4), .FPU_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_exc(fpu_exc), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .err_cnt(err_cnt)
  );

  // Core model: {unf, ovf, exc, result}; unknown/idle inputs give junk with exc set.
  function automatic logic [34:0] core_fn(input logic [3:0] op, input logic [31:0] a, b);
    case ({op, a, b})
      {4'd0, 32'h3F800000, 32'h40000000}: return {3'b000, 32'h40400000};
      {4'd0, 32'h40000000, 32'h40000000}: return {3'b000, 32'h40800000};
      {4'd0, 32'h3F800000, 32'h3F800000}: return {3'b000, 32'h40000000};
      {4'd1, 32'h3F800000, 32'h3F800000}: return {3'b000, 32'h00000000};
      {4'd2, 32'h40000000, 32'h40400000}: return {3'b000, 32'h40C00000};
      {4'd3, 32'h3F800000, 32'h40000000}: return {3'b000, 32'h3F000000};
      {4'd2, 32'h7F000000, 32'h7F000000}: return {3'b010, 32'h7F800000};
      default:                            return {3'b001, 32'hDEADBEEF};
    endcase
  endfunction

  always @(posedge Clk) begin
    if (Rst) {fpu_unf, fpu_ovf, fpu_exc, fpu_result} <= '0;
    else     {fpu_unf, fpu_ovf, fpu_exc, fpu_result} <= core_fn(fpu_op, fpu_a, fpu_b);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge; returns just after the negedge of the cycle following the fire.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] eres, input logic [3:0] eflg,
                      output int fc);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge Clk); #1; n++;
    end
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout tag %0d: cmd_ready stuck at 0, expected 1", tag);
      cmd_valid = 1'b0;
      fc = -1;
      return;
    end
    fc = cyc;
    n_fired++;
    sb.push_back('{eres, eflg, tag});
    @(negedge Clk); #1;
    chk("fpu_a", 64'(fpu_a), 64'(a));
    chk("fpu_b", 64'(fpu_b), 64'(b));
    chk("fpu_op", 64'(fpu_op), 64'((op > 4'd3) ? 4'hF : op));
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge Clk); n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge Clk);
    #1;
  endtask

  // Monitor: pops expected entries on each handshake, flags stale responses and hold violations.
  initial begin
    exp_t e, held;
    logic held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge Clk); #3;
      if (Rst) held_v = 1'b0;
      else begin
        if (held_v) begin
          chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
          chk("rsp_hold_data", 64'({rsp_result, rsp_flags, rsp_tag}), 64'(held));
        end
        if (rsp_valid && sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stale_rsp: got tag %0d result %08h, expected no response", rsp_tag, rsp_result);
        end else if (rsp_valid && rsp_ready) begin
          e = sb.pop_front();
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          pop_cyc.push_back(cyc);
        end
        held_v = rsp_valid & ~rsp_ready;
        held   = {rsp_result, rsp_flags, rsp_tag};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, base;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b1; Rst = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_fpu_op", 64'(fpu_op), 64'hF);
    chk("rst_fpu_a", 64'(fpu_a), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    Rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Single ADD: response three cycles after the fire cycle
    pop_cyc.delete();
    send(OP_ADD, 32'h3F800000, 32'h40000000, 4'd1, 32'h40400000, 4'b0000, fc);
    drain();
    chk("add_latency", 64'(pop_cyc.size() > 0 ? pop_cyc[0] - fc : -1), 64'd3);

    // Back-to-back MUL/DIV/SUB: responses on consecutive cycles
    pop_cyc.delete();
    send(OP_MUL, 32'h40000000, 32'h40400000, 4'd2, 32'h40C00000, 4'b0000, fc);
    send(OP_DIV, 32'h3F800000, 32'h40000000, 4'd3, 32'h3F000000, 4'b0000, fc);
    send(OP_SUB, 32'h3F800000, 32'h3F800000, 4'd4, 32'h00000000, 4'b0000, fc);
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk("b2b_gap1", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end

    // Backpressure: credit limits to four outstanding, rest issue once drained
    rsp_ready = 1'b0;
    base = n_fired;
    fork
      begin
        send(OP_ADD, 32'h3F800000, 32'h40000000, 4'd5,  32'h40400000, 4'b0000, fc);
        send(OP_MUL, 32'h40000000, 32'h40400000, 4'd6,  32'h40C00000, 4'b0000, fc);
        send(OP_DIV, 32'h3F800000, 32'h40000000, 4'd7,  32'h3F000000, 4'b0000, fc);
        send(OP_SUB, 32'h3F800000, 32'h3F800000, 4'd8,  32'h00000000, 4'b0000, fc);
        send(OP_ADD, 32'h40000000, 32'h40000000, 4'd9,  32'h40800000, 4'b0000, fc);
        send(OP_ADD, 32'h3F800000, 32'h3F800000, 4'd10, 32'h40000000, 4'b0000, fc);
      end
      begin
        repeat (12) @(negedge Clk);
        #1;
        chk("stall_fired", 64'(n_fired - base), 64'd4);
        chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("stall_all_fired", 64'(n_fired - base), 64'd6);
    chk("legal_err_cnt", 64'(err_cnt), 64'd0);

    // Illegal opcode: forced zero result, illegal flag, error counted
    send(4'd7, 32'h3F800000, 32'h40000000, 4'd11, 32'h00000000, 4'b1000, fc);
    exp_err++;
    drain();
    chk("ill_err_cnt", 64'(err_cnt), 64'(exp_err));

    // Overflowing MUL: core overflow reported in flags bit 1
    send(OP_MUL, 32'h7F000000, 32'h7F000000, 4'd12, 32'h7F800000, 4'b0010, fc);
    exp_err++;
    drain();
    chk("ovf_err_cnt", 64'(err_cnt), 64'(exp_err));

    // Reset with two buffered and two in flight
    rsp_ready = 1'b0;
    send(OP_ADD, 32'h3F800000, 32'h40000000, 4'd13, 32'h40400000, 4'b0000, fc);
    send(OP_MUL, 32'h40000000, 32'h40400000, 4'd14, 32'h40C00000, 4'b0000, fc);
    send(OP_DIV, 32'h3F800000, 32'h40000000, 4'd15, 32'h3F000000, 4'b0000, fc);
    send(OP_SUB, 32'h3F800000, 32'h3F800000, 4'd0,  32'h00000000, 4'b0000, fc);
    Rst = 1'b1;
    sb.delete();
    exp_err = 0;
    @(negedge Clk); #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_fpu_op", 64'(fpu_op), 64'hF);
    Rst = 1'b0;
    #1;
    chk("after_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp_ready = 1'b1;
    repeat (10) @(negedge Clk);
    #1;
    send(OP_ADD, 32'h40000000, 32'h40000000, 4'd3, 32'h40800000, 4'b0000, fc);
    drain();
    chk("final_err_cnt", 64'(err_cnt), 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
